// File: rtl/id_operand_fetch.sv
// IF/ID pipeline register plus 32x32 GPR file with Ra/Rb operand selection.
// Define ID_BYPASS_EN to compile in the same-cycle write-back bypass.
module id_operand_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  ra_sel,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic [4:0]  ra_addr,
    output logic [4:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data
);

    logic [31:0] regs [32];
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ra_arr;
    logic [31:0] rb_arr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_instruction <= 32'h0000_0000;
            id_pc          <= RESET_PC;
            id_valid       <= 1'b0;
        end else if (!stall) begin
            id_instruction <= if_instruction;
            id_pc          <= if_pc;
            id_valid       <= 1'b1;
        end
    end

    // Writes ignore stall/flush; $0 is never stored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wb_we && (wb_addr != 5'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign rs = id_instruction[25:21];
    assign rt = id_instruction[20:16];

    // Reserved and unknown selects fall back to the rs/rt order
    always_comb begin
        ra_addr = rs;
        rb_addr = rt;
        case (ra_sel)
            2'b11: begin
                ra_addr = rt;
                rb_addr = rs;
            end
            2'b01: begin
                ra_addr = 5'd2;
                rb_addr = 5'd4;
            end
            default: begin
                ra_addr = rs;
                rb_addr = rt;
            end
        endcase
    end

    assign ra_arr = (ra_addr == 5'd0) ? 32'h0 : regs[ra_addr];
    assign rb_arr = (rb_addr == 5'd0) ? 32'h0 : regs[rb_addr];

`ifdef ID_BYPASS_EN
    logic wb_live;
    assign wb_live = wb_we && (wb_addr != 5'd0);
    assign ra_data = (wb_live && (wb_addr == ra_addr)) ? wb_data : ra_arr;
    assign rb_data = (wb_live && (wb_addr == rb_addr)) ? wb_data : rb_arr;
`else
    assign ra_data = ra_arr;
    assign rb_data = rb_arr;
`endif

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: vector table, directed corner cases and
// randomized cycles checked against a behavioural model.
module tb_id_operand_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic [1:0]  ra_sel;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;

    id_operand_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .if_instruction(if_instruction), .if_pc(if_pc),
        .stall(stall), .flush(flush), .ra_sel(ra_sel),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_instruction(id_instruction), .id_pc(id_pc),
        .id_valid(id_valid), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  sel;
        logic [4:0]  exp_ra;
        logic [4:0]  exp_rb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] sel_addr(input logic [31:0] ins,
                                            input logic [1:0] sel,
                                            input bit port_b);
        logic [4:0] s;
        logic [4:0] t;
        s = ins[25:21];
        t = ins[20:16];
        if (sel == 2'b01) return port_b ? 5'd4 : 5'd2;
        if (sel == 2'b11) return port_b ? s : t;
        return port_b ? t : s;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef ID_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    task automatic set_in(input logic r, input logic st, input logic fl,
                          input logic [31:0] ins, input logic [31:0] pc,
                          input logic [1:0] sel, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd);
        rst = r; stall = st; flush = fl;
        if_instruction = ins; if_pc = pc; ra_sel = sel;
        wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    // Settle combinational outputs, then compare everything to the model
    task automatic settle();
        logic [4:0] ea;
        logic [4:0] eb;
        #2;
        ea = sel_addr(m_instr, ra_sel, 1'b0);
        eb = sel_addr(m_instr, ra_sel, 1'b1);
        chk("m_instr", id_instruction, m_instr);
        chk("m_pc", id_pc, m_pc);
        chk("m_valid", {31'b0, id_valid}, {31'b0, m_valid});
        chk("m_ra_addr", {27'b0, ra_addr}, {27'b0, ea});
        chk("m_rb_addr", {27'b0, rb_addr}, {27'b0, eb});
        if (!rst) begin
            chk("m_ra_data", ra_data, m_read(ea));
            chk("m_rb_data", rb_data, m_read(eb));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_instr = 32'h0; m_pc = RPC; m_valid = 1'b0;
        end else begin
            if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
            if (flush) begin
                m_instr = 32'h0; m_pc = RPC; m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = if_instruction; m_pc = if_pc; m_valid = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0128_5020, 2'b00, 5'd9, 5'd8};
        vecs[1] = '{32'h0003_1100, 2'b11, 5'd3, 5'd0};
        vecs[2] = '{32'h0000_000C, 2'b01, 5'd2, 5'd4};
        vecs[3] = '{32'h0128_5020, 2'b10, 5'd9, 5'd8};
        vecs[4] = '{32'h8D09_0004, 2'b00, 5'd8, 5'd9};
        vecs[5] = '{32'h00A4_1806, 2'b11, 5'd4, 5'd5};

        set_in(1, 0, 0, 32'h1234_5678, 32'h4, 2'b00, 1, 5'd3, 32'h55);
        tick();
        tick();

        // Reset state
        set_in(0, 1, 0, 32'h0, 32'h0, 2'b00, 0, 5'd0, 32'h0);
        settle();
        chk("rst_instr", id_instruction, 32'h0);
        chk("rst_pc", id_pc, RPC);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_ra_addr", {27'b0, ra_addr}, 32'h0);
        chk("rst_rb_addr", {27'b0, rb_addr}, 32'h0);
        chk("rst_ra_data", ra_data, 32'h0);
        chk("rst_rb_data", rb_data, 32'h0);

        // Address mapping table
        foreach (vecs[i]) begin
            set_in(0, 0, 0, vecs[i].instr, 32'h200 + i * 4, 2'b00, 0, 5'd0, 0);
            settle();
            tick();
            ra_sel = vecs[i].sel;
            stall = 1'b1;
            settle();
            chk($sformatf("vec%0d_ra", i), {27'b0, ra_addr}, {27'b0, vecs[i].exp_ra});
            chk($sformatf("vec%0d_rb", i), {27'b0, rb_addr}, {27'b0, vecs[i].exp_rb});
            chk($sformatf("vec%0d_valid", i), {31'b0, id_valid}, 32'h1);
        end

        // add $10,$9,$8 then write $9 while reading it
        set_in(0, 0, 0, 32'h0128_5020, 32'h304, 2'b00, 0, 5'd0, 0);
        settle();
        tick();
        set_in(0, 1, 0, 32'h0, 32'h0, 2'b00, 1, 5'd9, 32'hDEAD_BEEF);
        settle();
        chk("add_valid", {31'b0, id_valid}, 32'h1);
        chk("add_ra_addr", {27'b0, ra_addr}, 32'd9);
        chk("add_rb_addr", {27'b0, rb_addr}, 32'd8);
`ifdef ID_BYPASS_EN
        chk("byp_same", ra_data, 32'hDEAD_BEEF);
`else
        chk("nobyp_same", ra_data, 32'h0);
`endif
        tick();
        wb_we = 1'b0;
        settle();
        chk("wr_next", ra_data, 32'hDEAD_BEEF);

        // syscall with $2=10, $4=7
        set_in(0, 1, 0, 32'h0, 32'h0, 2'b00, 1, 5'd2, 32'd10);
        settle();
        tick();
        set_in(0, 1, 0, 32'h0, 32'h0, 2'b00, 1, 5'd4, 32'd7);
        settle();
        tick();
        set_in(0, 0, 0, 32'h0000_000C, 32'h308, 2'b00, 0, 5'd0, 0);
        settle();
        tick();
        set_in(0, 1, 0, 32'h0, 32'h0, 2'b01, 0, 5'd0, 0);
        settle();
        chk("sys_ra_addr", {27'b0, ra_addr}, 32'd2);
        chk("sys_rb_addr", {27'b0, rb_addr}, 32'd4);
        chk("sys_ra_data", ra_data, 32'd10);
        chk("sys_rb_data", rb_data, 32'd7);

        // sll $2,$3,4
        set_in(0, 0, 0, 32'h0003_1100, 32'h30C, 2'b11, 0, 5'd0, 0);
        settle();
        tick();
        settle();
        chk("sll_ra_addr", {27'b0, ra_addr}, 32'd3);
        chk("sll_rb_addr", {27'b0, rb_addr}, 32'd0);

        // Three stalled cycles with changing fetch data
        for (int c = 0; c < 3; c++) begin
            set_in(0, 1, 0, 32'hA000_0000 + c, 32'h400 + c, 2'b11, 0, 5'd0, 0);
            settle();
            tick();
            chk($sformatf("stall%0d_instr", c), id_instruction, 32'h0003_1100);
            chk($sformatf("stall%0d_pc", c), id_pc, 32'h30C);
        end
        set_in(0, 1, 1, 32'hBEEF_0000, 32'h500, 2'b00, 0, 5'd0, 0);
        settle();
        tick();
        set_in(0, 1, 0, 32'hBEEF_0000, 32'h500, 2'b00, 0, 5'd0, 0);
        settle();
        chk("flush_instr", id_instruction, 32'h0);
        chk("flush_valid", {31'b0, id_valid}, 32'h0);
        chk("flush_pc", id_pc, RPC);

        // Writes to $0 are discarded
        set_in(0, 1, 0, 32'h0, 32'h0, 2'b00, 1, 5'd0, 32'hFFFF_FFFF);
        settle();
        chk("r0_same", ra_data, 32'h0);
        tick();
        wb_we = 1'b0;
        settle();
        chk("r0_next", ra_data, 32'h0);

        // Reset mid-stream (with a write presented) wipes the array
        set_in(1, 1, 0, 32'h0, 32'h0, 2'b00, 1, 5'd5, 32'h1111_2222);
        tick();
        for (int r = 0; r < 32; r++) begin
            set_in(0, 0, 0, {6'b0, r[4:0], r[4:0], 16'b0}, 32'h600, 2'b00, 0, 5'd0, 0);
            settle();
            tick();
            stall = 1'b1;
            settle();
            chk($sformatf("clr%0d", r), ra_data, 32'h0);
        end

        // Randomized cycles against the model
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0),
                   $urandom, $urandom, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1),
                   5'($urandom_range(0, 31)), $urandom);
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
